period_meter: RTL and testbench

Measures the period, and optionally the high time, of a slow periodic input in units of `CLK` cycles. It is the receiving end of the clock-divider path: it takes a divided clock such as the 50 Hz tick and reports the divide ratio that produced it. It sits beside the divider in the alarm-system timing chain and supports self-check of the tick rate and frequency readout of external signals.

---
 rtl/timing_pkg.sv | 20 ++
 rtl/sync_edge.sv | 33 +++
 rtl/period_meter.sv | 160 ++++++++++++++++
 tb/tb_period_meter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared timing constants and FSM encoding for the alarm-system timing chain
// (clock divider, period meter, key/sensor edge detectors).
package timing_pkg;

   // Counter width used by the divider and the period meter unless overridden.
   localparam int unsigned CNT_W_DEF = 32;

   // One second of a 100 MHz CLK without an edge marks the input as stalled.
   localparam logic [31:0] TIMEOUT_DEF = 32'd100_000_000;

   // 100 MHz / 50 Hz: the ratio the divider uses and the meter reports back.
   localparam logic [31:0] DIV_50HZ = 32'd2_000_000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_STALLED = 2'd2
   } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; emits single-cycle rise/fall pulses.
// Shared by the period meter and the key/sensor inputs.
module sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s0_q;
   logic s1_q;
   logic s2_q;

   // NOTE: non-blocking assignments so each stage captures its predecessor's pre-edge value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s0_q <= 1'b0;
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s0_q <= d_i;
         s1_q <= s0_q;
         s2_q <= s1_q;
      end
   end

   assign level_o = s1_q;
   assign rise_o  = s1_q & ~s2_q;
   assign fall_o  = ~s1_q & s2_q;

endmodule

// File: rtl/period_meter.sv
// Measures period (and, with PERIOD_METER_DUTY_EN defined, high time) of a slow
// input in CLK cycles; flags STALL when no rising edge arrives within TIMEOUT.
module period_meter
   import timing_pkg::*;
#(
   parameter int unsigned          CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0]     TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SIGin,
   output logic [CNT_W-1:0] PERIOD,
   output logic [CNT_W-1:0] HIGHCNT,
   output logic             VALID,
   output logic             STALL
);

   logic s1;
   logic rise;
   logic fall;

   sync_edge u_sync (
      .clk_i   (CLK),
      .rst_i   (RST),
      .d_i     (SIGin),
      .level_o (s1),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // Period counter: restarts at 1 on a rise so it equals N at a rise N cycles later.
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (rise) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q < TIMEOUT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High time to report alongside the period at the next reported rise.
   logic [CNT_W-1:0] high_rpt;

`ifdef PERIOD_METER_DUTY_EN
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             fall_seen_q, fall_seen_d;

   always_comb begin
      hcnt_d      = hcnt_q;
      hold_d      = hold_q;
      fall_seen_d = fall_seen_q;
      if (rise) begin
         hcnt_d      = CNT_W'(1);
         fall_seen_d = 1'b0;
      end else if (s1 && (hcnt_q < TIMEOUT)) begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end
      if (fall) begin
         hold_d      = hcnt_q;
         fall_seen_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hcnt_q      <= '0;
         hold_q      <= '0;
         fall_seen_q <= 1'b0;
      end else begin
         hcnt_q      <= hcnt_d;
         hold_q      <= hold_d;
         fall_seen_q <= fall_seen_d;
      end
   end

   // No fall since the last rise means the input stayed high the whole period.
   assign high_rpt = fall_seen_q ? hold_q : cnt_q;
`else
   logic unused_duty;
   assign unused_duty = s1 ^ fall;
   assign high_rpt    = '0;
`endif

   meter_state_e     state_q, state_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] highcnt_q, highcnt_d;
   logic             valid_q, valid_d;
   logic             stall_q, stall_d;

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      highcnt_d = highcnt_q;
      valid_d   = 1'b0;
      stall_d   = stall_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            // A rise landing on the timeout cycle is still a valid period.
            if (rise) begin
               period_d  = cnt_q;
               highcnt_d = high_rpt;
               valid_d   = 1'b1;
            end else if (cnt_q == TIMEOUT) begin
               state_d   = ST_STALLED;
               stall_d   = 1'b1;
               period_d  = '0;
               highcnt_d = '0;
            end
         end
         ST_STALLED: begin
            if (rise) begin
               state_d = ST_MEASURE;
               stall_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         period_q  <= '0;
         highcnt_q <= '0;
         valid_q   <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         highcnt_q <= highcnt_d;
         valid_q   <= valid_d;
         stall_q   <= stall_d;
      end
   end

   assign PERIOD  = period_q;
   assign HIGHCNT = highcnt_q;
   assign VALID   = valid_q;
   assign STALL   = stall_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter with TIMEOUT=50; expected HIGHCNT follows
// whether PERIOD_METER_DUTY_EN is defined for the build.
module tb_period_meter;

   localparam int CNT_W     = 32;
   localparam int TMO       = 50;
   localparam int STALL_LAT = TMO + 3;
`ifdef PERIOD_METER_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST;
   logic             SIGin;
   logic [CNT_W-1:0] PERIOD;
   logic [CNT_W-1:0] HIGHCNT;
   logic             VALID;
   logic             STALL;

   period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (32'd50)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .SIGin   (SIGin),
      .PERIOD  (PERIOD),
      .HIGHCNT (HIGHCNT),
      .VALID   (VALID),
      .STALL   (STALL)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] period;
      logic [31:0] high;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   armed    = 1'b0;
   int   prev_p   = 0;
   int   prev_h   = 0;
   int   since_rise = 0;
   bit   stall_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [31:0] exp_high(input int h);
      return DUTY ? 32'(h) : 32'd0;
   endfunction

   task automatic tick();
      @(negedge CLK);
      since_rise++;
      if (STALL === 1'b1) stall_seen = 1'b1;
   endtask

   // A new rise reports the previous pulse if the meter is already measuring.
   task automatic do_rise(input int hi, input int lo);
      if (armed) exp_q.push_back('{period: 32'(prev_p), high: exp_high(prev_h)});
      prev_p     = hi + lo;
      prev_h     = hi;
      armed      = 1'b1;
      since_rise = 0;
   endtask

   task automatic pulse(input int hi, input int lo);
      do_rise(hi, lo);
      SIGin = 1'b1;
      repeat (hi) tick();
      SIGin = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic wait_stall(input string name);
      while (STALL !== 1'b1 && since_rise < STALL_LAT + 20) tick();
      check({name, "_latency"}, since_rise, STALL_LAT);
      check({name, "_period"}, PERIOD, 32'd0);
      check({name, "_highcnt"}, HIGHCNT, 32'd0);
      armed = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_period"}, PERIOD, 32'd0);
      check({name, "_highcnt"}, HIGHCNT, 32'd0);
      check({name, "_valid"}, 32'(VALID), 32'd0);
      check({name, "_stall"}, 32'(STALL), 32'd0);
   endtask

   // Monitor: every VALID strobe must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (VALID === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: VALID with PERIOD=%0d, none expected", PERIOD);
         end else begin
            mon_e = exp_q.pop_front();
            check("report_period", PERIOD, mon_e.period);
            check("report_highcnt", HIGHCNT, mon_e.high);
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RST   = 1'b1;
      SIGin = 1'b0;
      @(negedge CLK);
      check_reset_outputs("reset");
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (3) tick();

      // Divider loopback, DIV=10 with 50 % duty
      stall_seen = 1'b0;
      repeat (6) pulse(5, 5);
      check("loopback_no_stall", 32'(stall_seen), 32'd0);

      // Minimum period and odd period
      repeat (4) pulse(1, 1);
      repeat (3) pulse(3, 4);

      // Stall with input held low, then recovery
      repeat (2) pulse(5, 5);
      wait_stall("stall_low");
      repeat (5) tick();
      pulse(5, 5);
      check("recover_low_stall", 32'(STALL), 32'd0);
      repeat (3) pulse(5, 5);

      // Input stuck high, then recovery
      do_rise(5, 5);
      SIGin = 1'b1;
      wait_stall("stall_high");
      SIGin = 1'b0;
      repeat (5) tick();
      pulse(5, 5);
      check("recover_high_stall", 32'(STALL), 32'd0);
      repeat (2) pulse(5, 5);

      // Period exactly equal to TIMEOUT: rise wins, never stalls
      stall_seen = 1'b0;
      repeat (3) pulse(25, 25);
      check("edge_timeout_no_stall", 32'(stall_seen), 32'd0);

      // Reset midway through a period of 10
      pulse(5, 0);
      tick();
      tick();
      RST = 1'b1;
      @(negedge CLK);
      check_reset_outputs("mid_reset");
      RST   = 1'b0;
      armed = 1'b0;
      repeat (4) tick();
      repeat (3) pulse(5, 5);

      repeat (10) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
